// File: rtl/riscv_pkg.sv
// Shared RV32 constants used by the fetch stage and the control unit.
// Combinational definitions only; no latency, no backpressure.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam int unsigned FUNCT3_HI = 14;
  localparam int unsigned FUNCT3_LO = 12;

  function automatic logic [2:0] funct3_of(input logic [XLEN-1:0] instr);
    return instr[FUNCT3_HI:FUNCT3_LO];
  endfunction

endpackage

// File: rtl/instruction_fetch_imem.sv
// Word-addressed instruction store: combinational read, synchronous write.
// Read is zero-latency (read-before-write on a shared edge); write is never refused.
module imem
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]   rd_data
);

  logic [XLEN-1:0] mem [DEPTH];

  // Contents survive reset so a program can be loaded while the core is held.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, branch/stall priority and registered instruction for the control unit.
// One cycle pc_q -> instr_out; stall freezes all fetch state, a branch inserts one bubble.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned     IMEM_DEPTH = 256,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  localparam int unsigned    ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic              imem_wr_en,
  input  logic [ADDR_W-1:0] imem_wr_addr,
  input  logic [XLEN-1:0]   imem_wr_data,
  output logic [XLEN-1:0]   instr_out,
  output logic [XLEN-1:0]   pc_out,
  output logic              instr_valid,
  output logic              fetch_fault
);

  logic [XLEN-1:0]   pc_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]   rd_data;

  // High PC bits are ignored here, so out-of-range addresses alias into the array.
  assign rd_addr = pc_q[ADDR_W+1:2];

  imem #(
    .DEPTH (IMEM_DEPTH)
  ) u_imem (
    .clk     (clk),
    .wr_en   (imem_wr_en),
    .wr_addr (imem_wr_addr),
    .wr_data (imem_wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      instr_out   <= NOP_INSTR;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (branch_taken) begin
      // Misaligned targets are still followed with the low bits dropped; the fault is sticky.
      pc_q        <= {branch_target[XLEN-1:2], 2'b00};
      instr_out   <= NOP_INSTR;
      instr_valid <= 1'b0;
      if (branch_target[1:0] != 2'b00) begin
        fetch_fault <= 1'b1;
      end
    end else if (!stall) begin
      instr_out   <= rd_data;
      pc_out      <= pc_q;
      instr_valid <= 1'b1;
      pc_q        <= pc_q + 32'd4;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch against a word-array reference model.
module tb_instruction_fetch;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_wr_en = 1'b0;
  logic [7:0]  imem_wr_addr = '0;
  logic [31:0] imem_wr_data = '0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        fetch_fault;

  instruction_fetch #(
    .IMEM_DEPTH (DEPTH),
    .RESET_PC   (RPC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_wr_en    (imem_wr_en),
    .imem_wr_addr  (imem_wr_addr),
    .imem_wr_data  (imem_wr_data),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] m_pc, m_instr, m_pcout;
  logic        m_valid, m_fault;

  task automatic model_reset();
    m_pc = RPC; m_instr = NOP; m_pcout = 0; m_valid = 0; m_fault = 0;
  endtask

  // Behaviour at a clock edge: branch beats stall; memory write lands after the read.
  task automatic model_edge(input logic st, input logic br, input logic [31:0] tgt,
                            input logic we, input logic [7:0] wa, input logic [31:0] wd);
    if (reset) begin
      if (br) begin
        if (tgt % 4 != 0) m_fault = 1;
        m_pc    = tgt - (tgt % 4);
        m_instr = NOP;
        m_valid = 0;
      end else if (!st) begin
        m_instr = mem_m[(m_pc / 4) % DEPTH];
        m_pcout = m_pc;
        m_valid = 1;
        m_pc    = m_pc + 4;
      end
    end
    if (we) mem_m[wa] = wd;
  endtask

  task automatic push_exp();
    exp_t e;
    e.instr = m_instr; e.pc = m_pcout; e.valid = m_valid; e.fault = m_fault;
    exp_q.push_back(e);
  endtask

  // One clock: drive inputs away from the edge, advance the model, optionally assert reset mid-cycle.
  task automatic cycle(input logic rst_v, input logic st, input logic br, input logic [31:0] tgt,
                       input logic we, input logic [7:0] wa, input logic [31:0] wd,
                       input bit rst_mid);
    @(negedge clk);
    #1;
    reset = rst_v; stall = st; branch_taken = br; branch_target = tgt;
    imem_wr_en = we; imem_wr_addr = wa; imem_wr_data = wd;
    @(posedge clk);
    #1;
    model_edge(st, br, tgt, we, wa, wd);
    if (rst_mid) begin
      reset = 1'b0;
      model_reset();
    end
    push_exp();
  endtask

  task automatic run(input logic st, input logic br, input logic [31:0] tgt);
    cycle(1'b1, st, br, tgt, 1'b0, 8'd0, 32'd0, 1'b0);
  endtask

  // Monitor: every output sample is checked against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (instr_out !== e.instr) begin
          failures++;
          $display("FAIL instr_out t=%0t got=%h exp=%h", $time, instr_out, e.instr);
        end
        checks++;
        if (pc_out !== e.pc) begin
          failures++;
          $display("FAIL pc_out t=%0t got=%h exp=%h", $time, pc_out, e.pc);
        end
        checks++;
        if (instr_valid !== e.valid) begin
          failures++;
          $display("FAIL instr_valid t=%0t got=%b exp=%b", $time, instr_valid, e.valid);
        end
        checks++;
        if (fetch_fault !== e.fault) begin
          failures++;
          $display("FAIL fetch_fault t=%0t got=%b exp=%b", $time, fetch_fault, e.fault);
        end
      end
    end
  end

  initial begin
    logic [31:0] wd;
    logic [31:0] tgt;
    model_reset();
    // Program load while reset is held; reset outputs are checked every cycle.
    for (int i = 0; i < int'(DEPTH); i++) begin
      case (i)
        0:       wd = 32'h0050_0093;
        1:       wd = 32'h0020_81B3;
        8:       wd = 32'hFE00_0EE3;
        default: wd = $urandom;
      endcase
      cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 8'(i), wd, 1'b0);
    end

    run(0, 0, 0);                       // mem[0] at pc 0
    run(0, 0, 0);                       // mem[1] at pc 4
    run(1, 0, 0);
    run(1, 0, 0);
    run(0, 0, 0);                       // pc 8
    run(0, 1, 32'h20);                  // bubble
    run(0, 0, 0);                       // mem[8] at 0x20
    run(1, 1, 32'h40);                  // branch beats stall
    run(0, 0, 0);
    run(0, 1, 32'h22);                  // misaligned -> fault
    run(0, 0, 0);
    run(0, 0, 0);
    run(0, 1, 32'h3FC);                 // last word, then alias back to word 0
    run(0, 0, 0);
    run(0, 0, 0);
    run(0, 1, 32'hFFFF_FFFC);           // 32-bit PC wrap
    run(0, 0, 0);
    run(0, 0, 0);
    run(0, 1, 32'h8);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 8'd2, 32'hDEAD_BEEF, 1'b0);  // read-before-write
    run(0, 1, 32'h8);
    run(0, 0, 0);
    run(0, 0, 0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0, 1'b1);          // async reset mid-cycle
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0, 1'b0);
    run(0, 0, 0);                       // first fetch after release at RESET_PC

    for (int n = 0; n < 600; n++) begin
      tgt = 32'($urandom_range(0, 127) * 4);
      if ($urandom_range(0, 9) == 0) tgt = tgt + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) tgt = $urandom;
      cycle(1'b1,
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 6) == 0),
            tgt,
            1'($urandom_range(0, 2) == 0),
            8'($urandom_range(0, 255)),
            $urandom,
            bit'($urandom_range(0, 79) == 0));
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly upstream of the control unit. Holds the program counter and a word-addressed instruction memory, and presents one registered 32-bit instruction per cycle on instr_out. instr_out drives the control unit's instruction input (pc_reg). The stage also supports stall, branch redirect with a one-bubble flush, and a memory load port used for program loading.

Parameters:
IMEM_DEPTH, 256, number of 32-bit words in the instruction memory; must be a power of 2.
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
ADDR_W, $clog2(IMEM_DEPTH), word-index width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
stall  input  1  hold all fetch state this cycle
branch_taken  input  1  redirect PC to branch_target
branch_target  input  32  byte address of the redirect
imem_wr_en  input  1  write enable for the instruction memory
imem_wr_addr  input  ADDR_W  word index to write
imem_wr_data  input  32  instruction word to write
instr_out  output  32  registered instruction; feeds the control unit
pc_out  output  32  byte address of instr_out
instr_valid  output  1  instr_out is a real fetched instruction
fetch_fault  output  1  sticky flag: a misaligned branch target was received

Behaviour:
- Internal state: pc_q (32 bits), the address currently being fetched.
- Reset (reset=0, asynchronous):
  - pc_q = RESET_PC
  - instr_out = 32'h0000_0013 (NOP)
  - pc_out = 0
  - instr_valid = 0
  - fetch_fault = 0
  - Memory contents are not cleared.
- Memory read is combinational: mem[pc_q[ADDR_W+1:2]]. Output registers give 1-cycle latency from pc_q to instr_out.
- Normal edge (stall=0, branch_taken=0):
  - instr_out <= mem[idx]
  - pc_out <= pc_q
  - instr_valid <= 1
  - pc_q <= pc_q + 4
- Stall edge (stall=1, branch_taken=0): pc_q, instr_out, pc_out and instr_valid all hold.
- Branch edge (branch_taken=1, regardless of stall):
  - pc_q <= {branch_target[31:2], 2'b00}
  - instr_out <= NOP
  - instr_valid <= 0 (one bubble)
  - pc_out holds
  - The following edge fetches the target.
- Priority: reset > branch_taken > stall > normal.
- Misalignment: if branch_taken=1 and branch_target[1:0] != 0, fetch_fault <= 1. The flag stays set until reset. The target is still taken, with its low bits cleared.
- Wrap-around:
  - The PC is 32-bit modular: 0xFFFF_FFFC + 4 = 0.
  - Memory index uses only pc_q[ADDR_W+1:2], so addresses beyond the array alias modulo IMEM_DEPTH.
- Write port:
  - Synchronous write on the clock edge when imem_wr_en=1; active during stall and branch cycles too.
  - Same-edge write and fetch of the same word returns the old data (read-before-write).
- Reset asserted mid-operation clears all state immediately, without waiting for clk. The first fetch after release is at RESET_PC.

Decomposition:
- Shared package riscv_pkg:
  - XLEN=32
  - NOP_INSTR=32'h0000_0013
  - Opcode constants OP_R=7'b0110011, OP_I=7'b0010011, OP_B=7'b1100011
  - funct3 field position [14:12], shared with the control unit
- One sub-module, imem: IMEM_DEPTH x 32 array with a combinational read port and a synchronous write port. instruction_fetch owns the PC, priority logic and output registers.

Test Plan:
- Load mem[0]=0x00500093, mem[1]=0x002081B3, then release reset -> edge1: instr_out=0x00500093, pc_out=0, valid=1; edge2: instr_out=0x002081B3, pc_out=4.
- stall=1 for 2 cycles after edge2 -> instr_out stays 0x002081B3 and pc_out stays 4; on release the next edge gives pc_out=8.
- branch_taken=1, target=0x20, mem[8]=0xFE000EE3 -> next edge: instr_out=0x13, valid=0; following edge: instr_out=0xFE000EE3, pc_out=0x20, valid=1.
- branch_taken=1 with stall=1, target=0x40 -> branch wins: bubble, then pc_out=0x40. Separately, target=0x22 -> fetch_fault=1 (stays set), fetch from pc_out=0x20.
- IMEM_DEPTH=4, run sequentially -> pc_out=0x10 returns mem[0] contents.
- Write mem[2]=0xDEADBEEF on the same edge that fetches word 2 -> old word delivered; a refetch after a branch to 0x8 returns 0xDEADBEEF.
- Assert reset between edges mid-run -> outputs show reset values before the next clk edge; after release, pc_out=RESET_PC.
